bringup_pattern_gen: RTL and testbench

BRINGUP_PATTERN_GEN -- requirements
Module: bringup_pattern_gen

---
 rtl/bringup_pattern_gen_if.sv | 26 ++
 rtl/bringup_pattern_gen.sv | 155 +++++++++++++++
 tb/tb_bringup_pattern_gen.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/bringup_pattern_gen_if.sv
// UART-side byte handshake for the bring-up pattern generator: received
// bytes flow in, transmit requests flow out to a serialiser.
interface bringup_pattern_gen_if;
    logic       rx_valid_i;
    logic [7:0] rx_data_i;
    logic       tx_busy_i;
    logic       tx_write_o;
    logic [7:0] tx_data_o;

    // The generator is the master: it consumes rx/busy and drives the tx request.
    modport master (
        input  rx_valid_i,
        input  rx_data_i,
        input  tx_busy_i,
        output tx_write_o,
        output tx_data_o
    );

    modport slave (
        output rx_valid_i,
        output rx_data_i,
        output tx_busy_i,
        input  tx_write_o,
        input  tx_data_o
    );
endinterface

// File: rtl/bringup_pattern_gen.sv
// Board bring-up traffic source: emits a letter sweep, a byte counter or an
// echo of received bytes to a UART transmitter, paced by an interval tick.
module bringup_pattern_gen #(
    parameter int INTERVAL   = 120000,
    parameter int FIRST_CHAR = 65,
    parameter int LAST_CHAR  = 90,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    input  logic [1:0]             mode_i,
    bringup_pattern_gen_if.master  uart,
    output logic                   overflow_o,
    output logic                   tick_o
);

    localparam int CNT_W  = (INTERVAL > 2) ? $clog2(INTERVAL) : 1;
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] RELOAD     = CNT_W'(INTERVAL - 1);
    localparam logic [7:0]       FIRST_BYTE = 8'(FIRST_CHAR);
    localparam logic [7:0]       LAST_BYTE  = 8'(LAST_CHAR);

    typedef enum logic [1:0] {
        MODE_SWEEP = 2'd0,
        MODE_COUNT = 2'd1,
        MODE_ECHO  = 2'd2,
        MODE_IDLE  = 2'd3
    } mode_e;

    mode_e            mode;
    mode_e            mode_q;
    logic [CNT_W-1:0] counter;
    logic             pending;
    logic [7:0]       sweep;
    logic [7:0]       count;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [ADDR_W:0]  rd_ptr;
    logic [ADDR_W:0]  wr_ptr;

    logic       mode_changed;
    logic       fifo_empty;
    logic       fifo_full;
    logic       source_ready;
    logic [7:0] source_data;
    logic       send;
    logic       push;
    logic       pop;
    logic       push_accept;
    logic       timed_mode;

    assign mode         = mode_e'(mode_i);
    assign mode_changed = (mode != mode_q);
    assign timed_mode   = (mode == MODE_SWEEP) || (mode == MODE_COUNT);
    assign fifo_empty   = (rd_ptr == wr_ptr);
    assign fifo_full    = (rd_ptr[ADDR_W] != wr_ptr[ADDR_W]) &&
                          (rd_ptr[ADDR_W-1:0] == wr_ptr[ADDR_W-1:0]);

    always_comb begin
        source_ready = 1'b0;
        source_data  = 8'd0;
        case (mode)
            MODE_SWEEP: begin
                source_ready = pending;
                source_data  = sweep;
            end
            MODE_COUNT: begin
                source_ready = pending;
                source_data  = count;
            end
            MODE_ECHO: begin
                source_ready = !fifo_empty;
                source_data  = fifo_mem[rd_ptr[ADDR_W-1:0]];
            end
            default: begin
                source_ready = 1'b0;
                source_data  = 8'd0;
            end
        endcase
    end

    // Sends and pushes are held off in the cycle a mode change is seen, since
    // that edge flushes the queue and pending state left over from the old mode.
    assign send        = source_ready && !uart.tx_busy_i && !uart.tx_write_o && !mode_changed;
    assign push        = (mode == MODE_ECHO) && uart.rx_valid_i && !mode_changed;
    assign pop         = send && (mode == MODE_ECHO);
    assign push_accept = push && (!fifo_full || pop);

    always_ff @(posedge clock_i) begin
        if (push_accept) begin
            fifo_mem[wr_ptr[ADDR_W-1:0]] <= uart.rx_data_i;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            counter         <= RELOAD;
            tick_o          <= 1'b0;
            mode_q          <= MODE_SWEEP;
            pending         <= 1'b0;
            sweep           <= FIRST_BYTE;
            count           <= 8'd0;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            overflow_o      <= 1'b0;
            uart.tx_write_o <= 1'b0;
            uart.tx_data_o  <= 8'd0;
        end else begin
            if (counter == '0) begin
                counter <= RELOAD;
                tick_o  <= 1'b1;
            end else begin
                counter <= counter - CNT_W'(1);
                tick_o  <= 1'b0;
            end

            mode_q          <= mode;
            uart.tx_write_o <= send;
            if (send) begin
                uart.tx_data_o <= source_data;
            end

            // A tick that lands while a send is still owed is simply lost.
            if (mode_changed || (mode == MODE_IDLE)) begin
                pending <= 1'b0;
            end else if (send && timed_mode) begin
                pending <= 1'b0;
            end else if (tick_o && timed_mode) begin
                pending <= 1'b1;
            end

            if (send && (mode == MODE_SWEEP)) begin
                sweep <= (sweep == LAST_BYTE) ? FIRST_BYTE : sweep + 8'd1;
            end
            if (send && (mode == MODE_COUNT)) begin
                count <= count + 8'd1;
            end

            if (mode_changed) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push_accept) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end

            if (push && !push_accept) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bringup_pattern_gen.sv
// Randomised and scenario bench for bringup_pattern_gen, checked every cycle
// against a queue-based reference model of the traffic rules.
module tb_bringup_pattern_gen;

    localparam int INTERVAL   = 4;
    localparam int FIRST_CHAR = 65;
    localparam int LAST_CHAR  = 90;
    localparam int FIFO_DEPTH = 4;

    logic       clock_i   = 1'b0;
    logic       reset_n_i = 1'b1;
    logic [1:0] mode_i    = 2'd0;
    logic       overflow_o;
    logic       tick_o;

    bringup_pattern_gen_if uart ();

    bringup_pattern_gen #(
        .INTERVAL   (INTERVAL),
        .FIRST_CHAR (FIRST_CHAR),
        .LAST_CHAR  (LAST_CHAR),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock_i    (clock_i),
        .reset_n_i  (reset_n_i),
        .mode_i     (mode_i),
        .uart       (uart),
        .overflow_o (overflow_o),
        .tick_o     (tick_o)
    );

    always #5 clock_i = ~clock_i;

    int errors = 0;
    int checks = 0;

    // Reference model: what the outputs should read after each clock edge.
    int         m_cyc;
    bit         m_tick;
    bit         m_write;
    bit         m_pending;
    bit         m_overflow;
    int         m_data;
    int         m_sweep;
    int         m_count;
    int         m_prev_mode;
    logic [7:0] m_fifo [$];

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_cyc       = 0;
        m_tick      = 1'b0;
        m_write     = 1'b0;
        m_pending   = 1'b0;
        m_overflow  = 1'b0;
        m_data      = 0;
        m_sweep     = FIRST_CHAR;
        m_count     = 0;
        m_prev_mode = 0;
        m_fifo.delete();
    endtask

    task automatic modelAdvance(input int mode, input bit busy, input bit rx_valid, input logic [7:0] rx_data);
        bit changed;
        bit ready;
        bit send;
        bit timed;
        int src;
        changed = (mode != m_prev_mode);
        timed   = (mode == 0) || (mode == 1);
        ready   = 1'b0;
        src     = 0;
        if (mode == 0) begin
            ready = m_pending;
            src   = m_sweep;
        end else if (mode == 1) begin
            ready = m_pending;
            src   = m_count;
        end else if (mode == 2 && m_fifo.size() > 0) begin
            ready = 1'b1;
            src   = m_fifo[0];
        end
        send = ready && !busy && !m_write && !changed;

        if (changed || mode == 3) m_pending = 1'b0;
        else if (send && timed) m_pending = 1'b0;
        else if (m_tick && timed) m_pending = 1'b1;

        if (changed) begin
            m_fifo.delete();
        end else begin
            if (send && mode == 2) void'(m_fifo.pop_front());
            if (mode == 2 && rx_valid) begin
                if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(rx_data);
                else m_overflow = 1'b1;
            end
        end

        if (send && mode == 0) m_sweep = (m_sweep == LAST_CHAR) ? FIRST_CHAR : m_sweep + 1;
        if (send && mode == 1) m_count = (m_count + 1) % 256;

        m_write = send;
        if (send) m_data = src;
        m_cyc++;
        m_tick      = (m_cyc % INTERVAL) == 0;
        m_prev_mode = mode;
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic applyStimulus(input int mode, input bit busy, input bit rx_valid, input logic [7:0] rx_data);
        mode_i          = 2'(mode);
        uart.tx_busy_i  = busy;
        uart.rx_valid_i = rx_valid;
        uart.rx_data_i  = rx_data;
        modelAdvance(mode, busy, rx_valid, rx_data);
        @(posedge clock_i);
        #1;
        checkOutput("tick", int'(tick_o), int'(m_tick));
        checkOutput("tx_write", int'(uart.tx_write_o), int'(m_write));
        checkOutput("tx_data", int'(uart.tx_data_o), m_data);
        checkOutput("overflow", int'(overflow_o), int'(m_overflow));
    endtask

    task automatic doReset();
        reset_n_i = 1'b0;
        #1;
        checkOutput("rst_tx_write", int'(uart.tx_write_o), 0);
        checkOutput("rst_tx_data", int'(uart.tx_data_o), 0);
        checkOutput("rst_overflow", int'(overflow_o), 0);
        checkOutput("rst_tick", int'(tick_o), 0);
        modelReset();
        repeat (2) @(posedge clock_i);
        @(negedge clock_i);
        reset_n_i = 1'b1;
    endtask

    initial begin
        int  mode;
        bit  busy;
        bit  saw_write;
        logic [7:0] pushes [5];
        uart.tx_busy_i  = 1'b0;
        uart.rx_valid_i = 1'b0;
        uart.rx_data_i  = 8'd0;
        modelReset();
        #2;
        doReset();

        $display("[TB] sweep with wrap");
        for (int i = 0; i < 120; i++) applyStimulus(0, 1'b0, 1'b0, 8'd0);

        $display("[TB] count with busy across ticks");
        applyStimulus(1, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 14; i++) applyStimulus(1, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 10; i++) applyStimulus(1, 1'b0, 1'b0, 8'd0);

        $display("[TB] echo ordering");
        applyStimulus(2, 1'b1, 1'b0, 8'd0);
        applyStimulus(2, 1'b1, 1'b1, 8'h31);
        applyStimulus(2, 1'b1, 1'b1, 8'h32);
        applyStimulus(2, 1'b1, 1'b1, 8'h33);
        for (int i = 0; i < 10; i++) applyStimulus(2, 1'b0, 1'b0, 8'd0);

        $display("[TB] echo overflow");
        pushes = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        for (int i = 0; i < 5; i++) applyStimulus(2, 1'b1, 1'b1, pushes[i]);
        for (int i = 0; i < 15; i++) applyStimulus(2, 1'b0, 1'b0, 8'd0);

        $display("[TB] mode switch flushes queue");
        applyStimulus(2, 1'b1, 1'b1, 8'h61);
        applyStimulus(2, 1'b1, 1'b1, 8'h62);
        for (int i = 0; i < 12; i++) applyStimulus(0, 1'b0, 1'b0, 8'd0);

        $display("[TB] reset during send");
        saw_write = 1'b0;
        for (int i = 0; i < 20 && !saw_write; i++) begin
            applyStimulus(0, 1'b0, 1'b0, 8'd0);
            saw_write = m_write;
        end
        checkOutput("write_before_reset", int'(uart.tx_write_o), 1);
        #2;
        doReset();
        for (int i = 0; i < 12; i++) applyStimulus(0, 1'b0, 1'b0, 8'd0);

        $display("[TB] randomised traffic");
        mode = 0;
        busy = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) mode = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) busy = ~busy;
            applyStimulus(mode, busy, ($urandom_range(0, 9) < 3), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
